// File: rtl/osfm_output_shifter_pipe_if.sv
// Stream bundle between the multiplier core, the output shifter and the accumulator.
// Carries the product with its operand step counts in, and the rescaled result out.
interface osfm_output_shifter_pipe_if #(
    parameter int BITWIDTH        = 32,
    parameter int OSFM_BITWIDTH_I = 16,
    parameter int MAX_STEPS       = 2
);
    localparam int PW = 2 * OSFM_BITWIDTH_I;
    localparam int SW = $clog2(MAX_STEPS + 1);

    logic                in_valid;
    logic                in_ready;
    logic [PW-1:0]       shiftin;
    logic [SW-1:0]       steps_a;
    logic [SW-1:0]       steps_b;
    logic                out_valid;
    logic                out_ready;
    logic [BITWIDTH-1:0] shiftout;

    modport master (
        output in_valid, shiftin, steps_a, steps_b, out_ready,
        input  in_ready, out_valid, shiftout
    );

    modport slave (
        input  in_valid, shiftin, steps_a, steps_b, out_ready,
        output in_ready, out_valid, shiftout
    );
endinterface

// File: rtl/osfm_output_shifter_pipe.sv
// Two-stage output shifter: restores product scale by arithmetic right shift of k*SHIFTDISTANCE bits.
// Optional OSFM_OUTPUT_ROUND_EN adds round-half-up on the last shifted-out bit.
module osfm_output_shifter_pipe #(
    parameter int BITWIDTH        = 32,
    parameter int OSFM_BITWIDTH_I = 16,
    parameter int SHIFTDISTANCE   = 4,
    parameter int MAX_STEPS       = 2,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    osfm_output_shifter_pipe_if.slave    bus,
    input  logic                         cnt_clear,
    output logic [CNT_WIDTH-1:0]         shift_count
);
    localparam int PW  = 2 * OSFM_BITWIDTH_I;
    localparam int SW  = $clog2(MAX_STEPS + 1);
    localparam int KW  = $clog2(2 * MAX_STEPS + 1);
    localparam int SHW = $clog2(2 * MAX_STEPS * SHIFTDISTANCE + 1);

    generate
        if ((PW < BITWIDTH) || ((2 * MAX_STEPS * SHIFTDISTANCE) > (BITWIDTH - 1))) begin : g_param_check
            $error("osfm_output_shifter_pipe: illegal BITWIDTH/OSFM_BITWIDTH_I/SHIFTDISTANCE/MAX_STEPS combination");
        end
    endgenerate

    function automatic logic [SW-1:0] clamp_steps(input logic [SW-1:0] s);
        if (s > SW'(MAX_STEPS)) begin
            return SW'(MAX_STEPS);
        end else begin
            return s;
        end
    endfunction

    logic                 s1_valid_r;
    logic [BITWIDTH-1:0]  s1_top_r;
    logic [KW-1:0]        s1_k_r;
    logic                 s2_valid_r;
    logic [BITWIDTH-1:0]  shiftout_r;
    logic [CNT_WIDTH-1:0] count_r;

    logic                 s1_adv_s;
    logic                 in_ready_s;
    logic                 accept_s;
    logic                 s2_load_s;
    logic [KW-1:0]        k_in_s;
    logic [SHW-1:0]       sh_amt_s;
    logic [BITWIDTH-1:0]  shifted_s;
`ifdef OSFM_OUTPUT_ROUND_EN
    logic [BITWIDTH-1:0]  round_src_s;
`endif

    // Handshake: in_ready depends only on stage occupancy and out_ready, never on in_valid.
    always_comb begin
        s1_adv_s   = !s2_valid_r || bus.out_ready;
        in_ready_s = !s1_valid_r || s1_adv_s;
        accept_s   = bus.in_valid && in_ready_s;
        s2_load_s  = s1_valid_r && s1_adv_s;
        k_in_s     = KW'(clamp_steps(bus.steps_a)) + KW'(clamp_steps(bus.steps_b));
    end

    // Stage 2 datapath: arithmetic shift of the registered top slice, optional rounding.
    always_comb begin
        sh_amt_s  = SHW'(s1_k_r * SHIFTDISTANCE);
        shifted_s = BITWIDTH'($signed(s1_top_r) >>> sh_amt_s);
`ifdef OSFM_OUTPUT_ROUND_EN
        // For k>0 the shift is at least SHIFTDISTANCE, so sh_amt_s-1 is a valid bit position.
        round_src_s = s1_top_r >> (sh_amt_s - SHW'(1));
        if (s1_k_r != {KW{1'b0}}) begin
            shifted_s = shifted_s + {{(BITWIDTH-1){1'b0}}, round_src_s[0]};
        end else begin
            shifted_s = shifted_s;
        end
`endif
    end

    // Stage 1 register: capture product top slice and clamped step sum on acceptance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_top_r   <= {BITWIDTH{1'b0}};
            s1_k_r     <= {KW{1'b0}};
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            s1_top_r   <= bus.shiftin[PW-1 -: BITWIDTH];
            s1_k_r     <= k_in_s;
        end else if (s2_load_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // Stage 2 register: result held stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            shiftout_r <= {BITWIDTH{1'b0}};
        end else if (s2_load_s) begin
            s2_valid_r <= 1'b1;
            shiftout_r <= shifted_s;
        end else if (bus.out_ready) begin
            s2_valid_r <= 1'b0;
        end
    end

    // Saturating count of accepted transactions that needed a shift; clear wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= {CNT_WIDTH{1'b0}};
        end else if (cnt_clear) begin
            count_r <= {CNT_WIDTH{1'b0}};
        end else if (accept_s && (k_in_s != {KW{1'b0}}) && (count_r != {CNT_WIDTH{1'b1}})) begin
            count_r <= count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = s2_valid_r;
    assign bus.shiftout  = shiftout_r;
    assign shift_count   = count_r;
endmodule

// File: tb/tb_osfm_output_shifter_pipe.sv
// Scoreboard bench for osfm_output_shifter_pipe; expected results come from a floor-division model.
// Works with or without OSFM_OUTPUT_ROUND_EN defined.
module tb_osfm_output_shifter_pipe;
    localparam int BW  = 32;
    localparam int OBI = 16;
    localparam int PW  = 2 * OBI;
    localparam int SD  = 4;
    localparam int MS  = 2;
    localparam int CW  = 16;
    localparam int SW  = $clog2(MS + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cnt_clear = 1'b0;
    logic [CW-1:0] shift_count;

    osfm_output_shifter_pipe_if #(.BITWIDTH(BW), .OSFM_BITWIDTH_I(OBI), .MAX_STEPS(MS)) bus ();

    osfm_output_shifter_pipe #(
        .BITWIDTH(BW), .OSFM_BITWIDTH_I(OBI), .SHIFTDISTANCE(SD), .MAX_STEPS(MS), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .cnt_clear(cnt_clear), .shift_count(shift_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0] val;
        int            tag;
    } exp_t;

    exp_t          sbq[$];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    logic [CW-1:0] cnt_model = '0;
    bit            mon_en = 1'b0;
    bit            gold_en = 1'b0;
    logic [BW-1:0] gold_val = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scale restoration as floor(T / 2^(k*SD)), or floor((T + half) / 2^(k*SD)) when rounding.
    function automatic logic [BW-1:0] ref_shift(input logic [PW-1:0] p, input int a, input int b);
        longint t, d, q;
        int k;
        t = longint'($signed(p[PW-1 -: BW]));
        k = ((a > MS) ? MS : a) + ((b > MS) ? MS : b);
        d = longint'(1) << (k * SD);
`ifdef OSFM_OUTPUT_ROUND_EN
        if (k > 0) t = t + d / 2;
`endif
        q = t / d;
        if ((q * d != t) && (t < 0)) q = q - 1;
        return q[BW-1:0];
    endfunction

    // Reference model: on each edge record accepted transactions and the expected counter.
    always @(posedge clk) begin
        bit acc;
        int k;
        cyc++;
        if (!rst_n) begin
            sbq.delete();
            cnt_model = '0;
        end else begin
            acc = bus.in_valid && bus.in_ready;
            k = ((int'(bus.steps_a) > MS) ? MS : int'(bus.steps_a)) +
                ((int'(bus.steps_b) > MS) ? MS : int'(bus.steps_b));
            if (acc) begin
                sbq.push_back('{val: (gold_en ? gold_val : ref_shift(bus.shiftin, int'(bus.steps_a), int'(bus.steps_b))), tag: cyc});
            end
            if (cnt_clear) cnt_model = '0;
            else if (acc && k > 0 && cnt_model != {CW{1'b1}}) cnt_model = cnt_model + 1'b1;
        end
    end

    // Monitor: compare flow-control, counter and results against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            check("in_ready", 64'(bus.in_ready), 64'((sbq.size() < 2) || bus.out_ready));
            check("out_valid", 64'(bus.out_valid), 64'((sbq.size() > 0) && (sbq[0].tag < cyc)));
            check("shift_count", 64'(shift_count), 64'(cnt_model));
            if (bus.out_valid && sbq.size() > 0) begin
                if (bus.out_ready) begin
                    check("shiftout", 64'(bus.shiftout), 64'(sbq[0].val));
                    void'(sbq.pop_front());
                end else begin
                    check("shiftout_stall", 64'(bus.shiftout), 64'(sbq[0].val));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_gold(input logic [PW-1:0] d, input logic [SW-1:0] a, input logic [SW-1:0] b,
                             input logic [BW-1:0] g);
        bit acc;
        int guard;
        guard = 0;
        bus.in_valid = 1'b1;
        bus.shiftin  = d;
        bus.steps_a  = a;
        bus.steps_b  = b;
        gold_en      = 1'b1;
        gold_val     = g;
        do begin
            @(negedge clk);
            acc = bus.in_ready;
            tick();
            guard++;
        end while (!acc && guard < 100);
        if (!acc) check("send_timeout", 64'd0, 64'd1);
        bus.in_valid = 1'b0;
        gold_en      = 1'b0;
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int sent;
        bus.in_valid  = 1'b0;
        bus.shiftin   = '0;
        bus.steps_a   = '0;
        bus.steps_b   = '0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_shiftout", 64'(bus.shiftout), 64'h0);
        check("rst_count", 64'(shift_count), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        mon_en = 1'b1;
        tick();

        // Directed vectors with known results.
        send_gold(32'h80000000, 2'd1, 2'd0, 32'hF8000000);
        send_gold(32'h80000000, 2'd1, 2'd1, 32'hFF800000);
        send_gold(32'h80000000, 2'd3, 2'd3, 32'hFFFF8000);
        repeat (3) tick();
        @(negedge clk);
        check("count3", 64'(shift_count), 64'd3);
        tick();
        send_gold(32'h12380000, 2'd0, 2'd0, 32'h12380000);
        send_gold(32'h12380000, 2'd0, 2'd1, 32'h01238000);
`ifdef OSFM_OUTPUT_ROUND_EN
        send_gold(32'h12380008, 2'd0, 2'd1, 32'h01238001);
`else
        send_gold(32'h12380008, 2'd0, 2'd1, 32'h01238000);
`endif
        repeat (3) tick();
        @(negedge clk);
        check("count5", 64'(shift_count), 64'd5);
        tick();

        // Four-deep burst with the consumer stalled for cycles 3-5.
        sent = 0;
        bus.shiftin = PW'($urandom);
        bus.steps_a = SW'($urandom_range(3, 0));
        bus.steps_b = SW'($urandom_range(3, 0));
        for (int c = 0; c < 12; c++) begin
            bus.in_valid  = (sent < 4);
            bus.out_ready = !(c >= 3 && c <= 5);
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            if (c == 4) check("stall_in_ready", 64'(bus.in_ready), 64'd0);
            tick();
            if (acc) begin
                sent++;
                bus.shiftin = PW'($urandom);
                bus.steps_a = SW'($urandom_range(3, 0));
                bus.steps_b = SW'($urandom_range(3, 0));
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        check("burst_sent", 64'(sent), 64'd4);

        // Random traffic with random back-pressure and occasional clears.
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = ($urandom_range(3, 0) != 0);
            bus.out_ready = ($urandom_range(2, 0) != 0);
            cnt_clear     = ($urandom_range(31, 0) == 0);
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            tick();
            if (acc) begin
                bus.shiftin = PW'($urandom);
                bus.steps_a = SW'($urandom_range(3, 0));
                bus.steps_b = SW'($urandom_range(3, 0));
            end
        end
        cnt_clear = 1'b0;

        // Drive the counter into saturation.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.steps_a   = 2'd1;
        bus.steps_b   = 2'd0;
        for (int i = 0; i < 65540; i++) begin
            bus.shiftin = PW'($urandom);
            tick();
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("count_sat", 64'(shift_count), 64'hFFFF);
        tick();
        bus.in_valid = 1'b1;
        cnt_clear    = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        cnt_clear    = 1'b0;
        @(negedge clk);
        check("count_clear_prio", 64'(shift_count), 64'd0);
        tick();
        repeat (3) tick();

        // Reset with both stages occupied discards everything.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.steps_a   = 2'd2;
        bus.shiftin   = 32'hC0FFEE00;
        tick();
        bus.shiftin   = 32'h7654321F;
        tick();
        bus.in_valid  = 1'b0;
        @(negedge clk);
        check("full_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        check("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (4) tick();

        @(negedge clk);
        check("drain_empty", 64'(sbq.size()), 64'd0);
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/osfm_output_shifter_pipe.md
Name: osfm_output_shifter_pipe

Overview:
Parametrised, pipelined successor to the fixed-mode output shifter in the approximate multiplier datapath. Restores the scale of a truncated fixed-width product by arithmetic right shift. The shift is the sum of per-operand step counts from the low-input detectors, each step worth SHIFTDISTANCE bits. The block sits between the multiplier core and the accumulator, with valid/ready flow control and a saturating counter of shifted results.

Parameters:
BITWIDTH, 32, output width.
OSFM_BITWIDTH_I, 16, multiplier operand width; product width PW = 2*OSFM_BITWIDTH_I; PW >= BITWIDTH required.
SHIFTDISTANCE, 4, bits per shift step.
MAX_STEPS, 2, max steps per operand; 2*MAX_STEPS*SHIFTDISTANCE <= BITWIDTH-1 required (elaboration error otherwise).
CNT_WIDTH, 16, width of shifted-result counter.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  input transaction valid
in_ready  out  1  block can accept input
shiftin  in  PW  signed product from multiplier
steps_a  in  SW=$clog2(MAX_STEPS+1)  shift steps, operand A
steps_b  in  SW  shift steps, operand B
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
shiftout  out  BITWIDTH  rescaled signed result
cnt_clear  in  1  synchronous clear of shift_count
shift_count  out  CNT_WIDTH  accepted transactions with k>0, saturating

Behaviour:
- Single clock. Reset is synchronous and active-low. Reset clears all valids; out_valid=0, shiftout=0, shift_count=0, in_ready=1 on the first cycle after reset release.
- Reset asserted mid-operation discards all in-flight data; no output is produced for discarded data.
- Steps clamp: each of steps_a and steps_b is saturated to MAX_STEPS before use. k = clamp(a)+clamp(b), range 0..2*MAX_STEPS.
- Arithmetic: T = shiftin[PW-1 -: BITWIDTH]. shiftout = T >>> (k*SHIFTDISTANCE). Vacated MSBs are filled with shiftin[PW-1]. Lower PW-BITWIDTH product bits are discarded.
- Stage 1 registers shiftin and k on acceptance (in_valid && in_ready).
- Stage 2 computes the shift (and rounding, if enabled) and registers shiftout.
- Latency: 2 cycles from acceptance to out_valid when out_ready stays high. Throughput is 1 per cycle.
- Handshake, per stage:
  - s1_adv = !s2_valid || out_ready.
  - in_ready = !s1_valid || s1_adv; purely combinational, so bubbles collapse.
  - Stage 2 loads when s1_valid && s1_adv.
  - out_valid=1 with out_ready=0 holds shiftout stable until the handshake completes.
  - Simultaneous output handshake and new load in the same cycle: stage 2 is replaced, no bubble.
- Counter:
  - Increments by 1 on each acceptance with k>0.
  - Holds at all-ones.
  - cnt_clear has priority over a same-cycle increment: result is 0.
- in_valid must not be qualified by in_ready upstream. in_ready has no combinational path from in_valid.

Optional Feature:
Macro OSFM_OUTPUT_ROUND_EN.
- Defined: when k>0, stage 2 adds the bit at position k*SHIFTDISTANCE-1 of T to the shifted result (round-half-up toward +inf). The parameter constraint guarantees this cannot overflow. k=0 is unaffected.
- Undefined: plain truncating arithmetic shift.
- Latency and handshake are identical in both builds.

Test Plan:
- Reset then idle, defaults: out_valid=0, shiftout=0x00000000, shift_count=0, in_ready=1.
- shiftin=0x80000000, steps (1,0) -> shiftout=0xF8000000 two cycles later. Steps (1,1) -> 0xFF800000. Steps (3,3), clamped to (2,2) -> 0xFFFF8000. shift_count=3.
- shiftin=0x12380000, steps (0,0) -> 0x12380000, count unchanged. Steps (0,1) -> 0x01238000 in both builds; bit 3 of T is 0, so no round-up.
- shiftin=0x12380008, PW=BITWIDTH, steps (0,1): without rounding -> 0x01238000. With OSFM_OUTPUT_ROUND_EN -> 0x01238001.
- Back-to-back stream of 4 inputs, out_ready low for cycles 3-5: in_ready drops once both stages are full. Outputs appear in order, none lost or duplicated, and shiftout stays stable while stalled.
- shift_count preloaded to 0xFFFF by repeated k>0 transactions -> stays 0xFFFF. cnt_clear together with a k>0 acceptance -> 0. Reset asserted with both stages full -> out_valid=0 on the next cycle.
